vec_exec_sequencer: RTL and testbench

Sequences one decoded vector-processor instruction over the ALU datapath. It accepts the 5-bit `exec` field with a start/ready handshake and classifies the operation as scalar, vector or no-op. For vector operations it issues one beat per group of `LANES` elements, then tracks the fixed-latency ALU pipeline so write-back strobes line up with results. It sits between instruction decode and the ALU control/register-file ports.

---
 rtl/vp_pkg.sv | 58 +++++
 rtl/vec_wb_pipe.sv | 50 +++++
 rtl/vec_exec_sequencer.sv | 146 ++++++++++++++
 tb/tb_vec_exec_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared types, opcode constants and decode helpers for the vector execution sequencer.
package vp_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Operation class derived from the exec field
  typedef enum logic [1:0] {
    CLS_NOP    = 2'd0,
    CLS_SCALAR = 2'd1,
    CLS_VECTOR = 2'd2
  } op_class_e;

  // ALU opcodes carried in exec[3:1]
  localparam logic [2:0] OPC_MOV_E  = 3'b000;
  localparam logic [2:0] OPC_MOV_EV = 3'b001;
  localparam logic [2:0] OPC_ADD_E  = 3'b010;
  localparam logic [2:0] OPC_SUB_E  = 3'b011;
  localparam logic [2:0] OPC_MUL_VE = 3'b100;
  localparam logic [2:0] OPC_ADD_VV = 3'b101;
  localparam logic [2:0] OPC_DIV_VE = 3'b110;
  localparam logic [2:0] OPC_NOP    = 3'b111;

  // Classify an exec field; unknown/func encodings fall back to NOP.
  function automatic op_class_e op_class(input logic [4:0] exec);
    logic unused_lsb;
    op_class_e cls;
    unused_lsb = exec[0];
    if (exec[4] == 1'b1) begin
      cls = CLS_NOP;
    end else begin
      case (exec[3:1])
        OPC_MOV_E, OPC_ADD_E, OPC_SUB_E:             cls = CLS_SCALAR;
        OPC_MOV_EV, OPC_MUL_VE, OPC_ADD_VV, OPC_DIV_VE: cls = CLS_VECTOR;
        OPC_NOP:                                      cls = CLS_NOP;
        default:                                      cls = CLS_NOP;
      endcase
    end
    return cls;
  endfunction

  // ALU opcode presented to the datapath: func instructions map to NOP.
  function automatic logic [2:0] alu_op(input logic [4:0] exec);
    logic [2:0] op;
    if (exec[4] == 1'b1) begin
      op = OPC_NOP;
    end else begin
      op = exec[3:1];
    end
    return op;
  endfunction

endpackage

// File: rtl/vec_wb_pipe.sv
// Fixed-latency write-back tracker: shifts {valid, idx} of each issued beat
// so it emerges exactly ALU_LAT cycles after issue.
module vec_wb_pipe
  import vp_pkg::*;
#(
  parameter int ALU_LAT = 2,
  parameter int IDXW    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [IDXW-1:0] i_idx,
  output logic            o_valid,
  output logic [IDXW-1:0] o_idx,
  output logic            o_empty
);

  logic [ALU_LAT-1:0]           r_vld;
  logic [ALU_LAT-1:0][IDXW-1:0] r_idx;
  logic                         w_empty;

  // Shift register always advances; flushed by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= {ALU_LAT{1'b0}};
      r_idx <= {(ALU_LAT*IDXW){1'b0}};
    end else begin
      r_vld[0] <= i_valid;
      r_idx[0] <= i_valid ? i_idx : {IDXW{1'b0}};
      for (int i = 1; i < ALU_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  // Empty means nothing is queued behind the output stage, so with no new
  // input the pipe holds no valid entry after the coming edge.
  always_comb begin
    w_empty = 1'b1;
    for (int i = 0; i < ALU_LAT - 1; i++) begin
      w_empty = w_empty & ~r_vld[i];
    end
  end

  assign o_valid = r_vld[ALU_LAT-1];
  assign o_idx   = r_idx[ALU_LAT-1];
  assign o_empty = w_empty;

endmodule

// File: rtl/vec_exec_sequencer.sv
// Sequences one decoded vector instruction: accepts exec on start/ready,
// issues one beat per LANES elements, and tracks ALU write-back.
module vec_exec_sequencer
  import vp_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int VLEN    = 16,
  parameter int ALU_LAT = 2,
  parameter int IDXW    = $clog2(VLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      exec,
  input  logic            stall,
  output logic            ready,
  output logic            busy,
  output logic [2:0]      op_alu,
  output logic            is_vector,
  output logic            issue_valid,
  output logic [IDXW-1:0] issue_idx,
  output logic            wb_valid,
  output logic [IDXW-1:0] wb_idx,
  output logic            done
);

  localparam int              NBEATS   = VLEN / LANES;
  localparam logic [IDXW-1:0] LAST_VEC = IDXW'(NBEATS - 1);

  seq_state_e      r_state;
  seq_state_e      w_state_nxt;
  logic [2:0]      r_op_alu;
  logic            r_is_vector;
  logic [IDXW-1:0] r_beat;
  logic [IDXW-1:0] r_last_beat;
  logic            w_accept;
  logic            w_issue;
  logic [IDXW-1:0] w_issue_idx;
  logic            w_pipe_empty;
  op_class_e       w_cls;

  assign w_cls    = op_class(exec);
  assign w_accept = (r_state == ST_IDLE) && start;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and issue decode; stall gates issue in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_cls == CLS_NOP) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          w_issue = 1'b1;
          if (r_beat == r_last_beat) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (w_pipe_empty) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the instruction on acceptance and step the beat counter on issue;
  // the counter saturates at the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_alu    <= OPC_NOP;
      r_is_vector <= 1'b0;
      r_beat      <= {IDXW{1'b0}};
      r_last_beat <= {IDXW{1'b0}};
    end else if (w_accept) begin
      r_op_alu    <= alu_op(exec);
      r_is_vector <= (w_cls == CLS_VECTOR);
      r_beat      <= {IDXW{1'b0}};
      r_last_beat <= (w_cls == CLS_VECTOR) ? LAST_VEC : {IDXW{1'b0}};
    end else if (w_issue && (r_beat != r_last_beat)) begin
      r_beat <= r_beat + {{(IDXW-1){1'b0}}, 1'b1};
    end
  end

  // Element index of the beat being issued; zero when nothing issues.
  always_comb begin
    if (w_issue) begin
      w_issue_idx = IDXW'(r_beat * IDXW'(LANES));
    end else begin
      w_issue_idx = {IDXW{1'b0}};
    end
  end

  vec_wb_pipe #(
    .ALU_LAT (ALU_LAT),
    .IDXW    (IDXW)
  ) u_wb_pipe (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (w_issue),
    .i_idx   (w_issue_idx),
    .o_valid (wb_valid),
    .o_idx   (wb_idx),
    .o_empty (w_pipe_empty)
  );

  assign ready       = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign op_alu      = r_op_alu;
  assign is_vector   = r_is_vector;
  assign issue_valid = w_issue;
  assign issue_idx   = w_issue_idx;

endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Directed, table-driven bench for vec_exec_sequencer (LANES=4, VLEN=16, ALU_LAT=2).
module tb_vec_exec_sequencer;

  localparam int LANES   = 4;
  localparam int VLEN    = 16;
  localparam int ALU_LAT = 2;
  localparam int IDXW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [4:0]      exec;
  logic            stall;
  logic            ready;
  logic            busy;
  logic [2:0]      op_alu;
  logic            is_vector;
  logic            issue_valid;
  logic [IDXW-1:0] issue_idx;
  logic            wb_valid;
  logic [IDXW-1:0] wb_idx;
  logic            done;

  int checks = 0;
  int errors = 0;

  vec_exec_sequencer #(
    .LANES   (LANES),
    .VLEN    (VLEN),
    .ALU_LAT (ALU_LAT),
    .IDXW    (IDXW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .exec        (exec),
    .stall       (stall),
    .ready       (ready),
    .busy        (busy),
    .op_alu      (op_alu),
    .is_vector   (is_vector),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .wb_valid    (wb_valid),
    .wb_idx      (wb_idx),
    .done        (done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // One instruction: stall/issue/wb masks are indexed by cycle (cycle 1 follows the accepting edge).
  typedef struct {
    logic [4:0]  ex;
    logic [15:0] stall_m;
    logic [15:0] iss_m;
    logic [15:0] wb_m;
    int          done_c;
    logic [2:0]  op;
    logic        vec;
  } vec_t;

  localparam int NVEC = 9;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Start one instruction and compare every output for 12 cycles.
  task automatic run_vec(input int n, input vec_t v);
    int ni = 0;
    int nw = 0;
    logic [IDXW-1:0] ei;
    logic [IDXW-1:0] ew;
    logic [31:0] a;
    logic [31:0] e;
    @(negedge clk);
    chk($sformatf("vec%0d_ready_before", n), {31'd0, ready}, 32'd1);
    start = 1'b1;
    exec  = v.ex;
    stall = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      exec  = 5'b11111;
      stall = v.stall_m[c];
      #1;
      ei = v.iss_m[c] ? IDXW'(ni * LANES) : 4'd0;
      ew = v.wb_m[c]  ? IDXW'(nw * LANES) : 4'd0;
      a = {19'd0, issue_valid, issue_idx, wb_valid, wb_idx, done, ready, busy};
      e = {19'd0, v.iss_m[c], ei, v.wb_m[c], ew, (c == v.done_c), (c > v.done_c), (c <= v.done_c)};
      chk($sformatf("vec%0d_cyc%0d_iv_ii_wv_wi_dn_rdy_bsy", n, c), a, e);
      if (v.iss_m[c]) ni++;
      if (v.wb_m[c]) nw++;
      if (c == 1) begin
        chk($sformatf("vec%0d_op_alu", n), {29'd0, op_alu}, {29'd0, v.op});
        chk($sformatf("vec%0d_is_vector", n), {31'd0, is_vector}, {31'd0, v.vec});
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    int dcnt;
    int dcyc;
    int bad;
    logic op_ok;

    // exec      stall     issue     wb        done  op      vec
    tbl[0] = '{5'b01010, 16'h0000, 16'h001E, 16'h0078, 7, 3'b101, 1'b1};
    tbl[1] = '{5'b00100, 16'h0000, 16'h0002, 16'h0008, 4, 3'b010, 1'b0};
    tbl[2] = '{5'b10000, 16'h0000, 16'h0000, 16'h0000, 1, 3'b111, 1'b0};
    tbl[3] = '{5'b01011, 16'h000C, 16'h0072, 16'h01C8, 9, 3'b101, 1'b1};
    tbl[4] = '{5'b00000, 16'h0000, 16'h0002, 16'h0008, 4, 3'b000, 1'b0};
    tbl[5] = '{5'b00010, 16'h0000, 16'h001E, 16'h0078, 7, 3'b001, 1'b1};
    tbl[6] = '{5'b01101, 16'h0004, 16'h003A, 16'h00E8, 8, 3'b110, 1'b1};
    tbl[7] = '{5'b01110, 16'h0000, 16'h0000, 16'h0000, 1, 3'b111, 1'b0};
    tbl[8] = '{5'b10110, 16'h0000, 16'h0000, 16'h0000, 1, 3'b111, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    exec  = 5'b00000;
    #1;
    chk("reset_values",
        {17'd0, ready, busy, op_alu, is_vector, issue_valid, issue_idx, wb_valid, wb_idx, done},
        {17'd0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, tbl[i]);
    end

    // start with a different exec while busy must be ignored
    @(negedge clk);
    start = 1'b1;
    exec  = 5'b01000;
    dcnt  = 0;
    dcyc  = 0;
    op_ok = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = (c == 2);
      exec  = (c == 2) ? 5'b00100 : 5'b01000;
      #1;
      if (done) begin
        dcnt++;
        dcyc = c;
      end
      if (op_alu !== 3'b100) op_ok = 1'b0;
    end
    start = 1'b0;
    chk("busy_start_done_count", dcnt, 32'd1);
    chk("busy_start_done_cycle", dcyc, 32'd7);
    chk("busy_start_op_stable", {31'd0, op_ok}, 32'd1);

    // reset in the middle of a vector op
    @(negedge clk);
    start = 1'b1;
    exec  = 5'b01101;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("midop_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midop_async_reset_values",
        {17'd0, ready, busy, op_alu, is_vector, issue_valid, issue_idx, wb_valid, wb_idx, done},
        {17'd0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (wb_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) bad++;
    end
    chk("midop_no_wb_done_after_rst", bad, 32'd0);
    run_vec(100, tbl[1]);
    run_vec(101, tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
